rename_dispatch: RTL and testbench
==================================

Name: rename_dispatch

Overview:
- Stage directly upstream of the issue queue. Takes one decoded ALU instruction per cycle with architectural register operands.
- Renames sources through a register map table and allocates a fresh physical destination from a free-list FIFO.
- Presents the renamed instruction on the issue-queue load interface (insn/inp1/inp2/dst) in the same cycle.
- Commit returns physical registers to the free list.

Parameters:
ARCH_REGS, 16, number of architectural registers; arch index width is clog2(ARCH_REGS)
PHYS_REGS, 32, number of physical registers; physical index width is REG_ADDR_LEN (5)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
dec_valid  in  1  decoded instruction present
dec_func  in  ALU1_FUNC  operation
dec_src1  in  clog2(ARCH_REGS)  arch source 1
dec_src2  in  clog2(ARCH_REGS)  arch source 2
dec_dst  in  clog2(ARCH_REGS)  arch destination
dec_ready  out  1  instruction accepted this cycle when dec_valid is also high
iq_full  in  1  issue queue is_full
iq_load  out  1  load strobe to issue queue
iq_insn  out  ALU1_FUNC  renamed op
iq_inp1  out  REG_ADDR_LEN  physical source 1
iq_inp2  out  REG_ADDR_LEN  physical source 2
iq_dst  out  REG_ADDR_LEN  newly allocated physical destination
iq_old_dst  out  REG_ADDR_LEN  previous mapping of dec_dst, for the commit tracker
free_valid  in  1  commit returns a register
free_preg  in  REG_ADDR_LEN  register being returned
free_count  out  REG_ADDR_LEN+1  entries currently in the free list

Behaviour:
- Reset (async):
  - Map table is identity (arch i -> phys i).
  - Free list holds phys ARCH_REGS..PHYS_REGS-1 in ascending order; head=0, tail=PHYS_REGS-ARCH_REGS, free_count=PHYS_REGS-ARCH_REGS (16).
  - All outputs go to 0 while reset is high.
- dec_ready:
  - Combinational: !iq_full && (free_count!=0 || dec_dst==0).
- Accept:
  - Accept = dec_valid && dec_ready. iq_load = accept, in the same cycle (zero latency).
  - iq_* fields are driven combinationally from dec_* and the map table; they are 0 when not accepting.
- Source lookup:
  - Sources read the map table before the destination update. src==dst in the same instruction gets the old mapping.
- Destination != 0:
  - iq_dst = free-list head entry; iq_old_dst = map[dec_dst].
  - At posedge: map[dec_dst] <= iq_dst; head advances modulo PHYS_REGS; count decrements.
- Destination == 0:
  - Arch reg 0 is never renamed: iq_dst=0, iq_old_dst=0, no pop. Accepted even when free_count==0.
  - map[0] stays 0 for all time.
- Free:
  - free_valid with free_preg!=0 pushes at tail at posedge; tail wraps modulo PHYS_REGS; count increments.
  - free_preg==0 is ignored.
  - A push when free_count==PHYS_REGS-1 is ignored (overflow guard).
- Simultaneous push and pop in one cycle: both pointers move, count unchanged.
- Empty free list (count 0): dec_ready low for dst!=0. A same-cycle free is not bypassed (see optional feature); it becomes usable next cycle.
- iq_full high: no accept, no state change from dispatch. Frees still proceed.
- Reset mid-operation: all renaming state is discarded and the reset state is restored immediately.

Optional Feature:
RENAME_FREE_BYPASS_EN:
- Defined: when free_count==0, free_valid=1, free_preg!=0 and dec_dst!=0, dec_ready may assert.
  - iq_dst = free_preg, forwarded combinationally.
  - Push and pop cancel: pointers and count are unchanged; map is updated.
- Undefined: no bypass; dec_ready stays low until the next cycle.

Test Plan:
1. Reset, then dispatch ADD src1=1 src2=2 dst=3 -> iq_load=1, iq_inp1=1, iq_inp2=2, iq_dst=16, iq_old_dst=3, free_count 16->15.
2. Dispatch SUB src1=3 src2=3 dst=3 right after scenario 1 -> iq_inp1=16, iq_inp2=16, iq_dst=17, iq_old_dst=16.
3. Hold iq_full=1 with dec_valid=1 for 3 cycles -> dec_ready=0, iq_load=0, free_count unchanged; drop iq_full -> dispatch proceeds next cycle.
4. Dispatch 16 instructions with dst!=0 -> free_count=0, dec_ready=0; dispatch with dst=0 -> accepted, iq_dst=0; free_valid with preg 5 -> next cycle dec_ready=1, iq_dst=5.
5. Same cycle: dispatch dst=4 and free preg 20 with count=8 -> free_count stays 8; head and tail both advance.
6. Assert reset mid-stream after 5 dispatches -> next dispatch of src1=3 dst=3 gives iq_inp1=3, iq_dst=16, free_count=16.

Source files
------------

// File: rtl/rename_dispatch.sv
// Register rename / dispatch stage: map-table source lookup, free-list destination allocation,
// zero-latency issue-queue load. Optional free-list bypass on empty under RENAME_FREE_BYPASS_EN.
module rename_dispatch #(
    parameter int ARCH_REGS    = 16,
    parameter int PHYS_REGS    = 32,
    parameter int ALU1_FUNC_W  = 4,
    localparam int ARCH_W       = $clog2(ARCH_REGS),
    localparam int REG_ADDR_LEN = $clog2(PHYS_REGS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    dec_valid,
    input  logic [ALU1_FUNC_W-1:0]  dec_func,
    input  logic [ARCH_W-1:0]       dec_src1,
    input  logic [ARCH_W-1:0]       dec_src2,
    input  logic [ARCH_W-1:0]       dec_dst,
    output logic                    dec_ready,
    input  logic                    iq_full,
    output logic                    iq_load,
    output logic [ALU1_FUNC_W-1:0]  iq_insn,
    output logic [REG_ADDR_LEN-1:0] iq_inp1,
    output logic [REG_ADDR_LEN-1:0] iq_inp2,
    output logic [REG_ADDR_LEN-1:0] iq_dst,
    output logic [REG_ADDR_LEN-1:0] iq_old_dst,
    input  logic                    free_valid,
    input  logic [REG_ADDR_LEN-1:0] free_preg,
    output logic [REG_ADDR_LEN:0]   free_count
);

    localparam int FREE_INIT = PHYS_REGS - ARCH_REGS;
    localparam logic [REG_ADDR_LEN-1:0] LAST_PTR  = REG_ADDR_LEN'(PHYS_REGS - 1);
    localparam logic [REG_ADDR_LEN-1:0] TAIL_INIT = REG_ADDR_LEN'(FREE_INIT);
    localparam logic [REG_ADDR_LEN-1:0] PTR_ONE   = REG_ADDR_LEN'(1);
    localparam logic [REG_ADDR_LEN:0]   CNT_INIT  = (REG_ADDR_LEN+1)'(FREE_INIT);
    localparam logic [REG_ADDR_LEN:0]   CNT_FULL  = (REG_ADDR_LEN+1)'(PHYS_REGS - 1);
    localparam logic [REG_ADDR_LEN:0]   CNT_ONE   = (REG_ADDR_LEN+1)'(1);

    logic [REG_ADDR_LEN-1:0] r_map [ARCH_REGS];
    logic [REG_ADDR_LEN-1:0] r_fl  [PHYS_REGS];
    logic [REG_ADDR_LEN-1:0] r_head;
    logic [REG_ADDR_LEN-1:0] r_tail;
    logic [REG_ADDR_LEN:0]   r_count;

    logic [REG_ADDR_LEN-1:0] w_map_init [ARCH_REGS];
    logic [REG_ADDR_LEN-1:0] w_fl_init  [PHYS_REGS];

    // Reset images: identity map, free list preloaded with the non-architectural registers.
    genvar gi;
    generate
        for (gi = 0; gi < ARCH_REGS; gi++) begin : g_map_init
            assign w_map_init[gi] = REG_ADDR_LEN'(gi);
        end
        for (gi = 0; gi < PHYS_REGS; gi++) begin : g_fl_init
            if (gi < FREE_INIT) begin : g_used
                assign w_fl_init[gi] = REG_ADDR_LEN'(gi + ARCH_REGS);
            end else begin : g_unused
                assign w_fl_init[gi] = '0;
            end
        end
    endgenerate

    function automatic logic [REG_ADDR_LEN-1:0] next_ptr(input logic [REG_ADDR_LEN-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_ONE;
    endfunction

    logic                    w_dst_nz;
    logic                    w_free_ok;
    logic                    w_bypass;
    logic                    w_ready;
    logic                    w_accept;
    logic                    w_byp_take;
    logic                    w_pop;
    logic                    w_push;
    logic                    w_map_we;
    logic [REG_ADDR_LEN-1:0] w_new_dst;

    assign w_dst_nz  = (dec_dst != '0);
    assign w_free_ok = free_valid && (free_preg != '0);

`ifdef RENAME_FREE_BYPASS_EN
    assign w_bypass = (r_count == '0) && w_free_ok && w_dst_nz;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_ready    = !reset && !iq_full && ((r_count != '0) || !w_dst_nz || w_bypass);
    assign w_accept   = dec_valid && w_ready;
    assign w_byp_take = w_accept && w_bypass;
    assign w_pop      = w_accept && w_dst_nz && !w_bypass;
    // A bypassed register never enters the list, so the push is suppressed along with the pop.
    assign w_push     = w_free_ok && !w_byp_take && (r_count != CNT_FULL);
    assign w_map_we   = w_pop || w_byp_take;
    assign w_new_dst  = w_byp_take ? free_preg : r_fl[r_head];

    assign dec_ready  = w_ready;
    assign iq_load    = w_accept;
    assign iq_insn    = w_accept ? dec_func : '0;
    assign iq_inp1    = w_accept ? r_map[dec_src1] : '0;
    assign iq_inp2    = w_accept ? r_map[dec_src2] : '0;
    assign iq_dst     = (w_accept && w_dst_nz) ? w_new_dst : '0;
    assign iq_old_dst = (w_accept && w_dst_nz) ? r_map[dec_dst] : '0;
    assign free_count = reset ? '0 : r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ARCH_REGS; i++) r_map[i] <= w_map_init[i];
            for (int i = 0; i < PHYS_REGS; i++) r_fl[i] <= w_fl_init[i];
            r_head  <= '0;
            r_tail  <= TAIL_INIT;
            r_count <= CNT_INIT;
        end else begin
            if (w_map_we) r_map[dec_dst] <= w_new_dst;
            if (w_pop) r_head <= next_ptr(r_head);
            if (w_push) begin
                r_fl[r_tail] <= free_preg;
                r_tail       <= next_ptr(r_tail);
            end
            if (w_push && !w_pop)      r_count <= r_count + CNT_ONE;
            else if (w_pop && !w_push) r_count <= r_count - CNT_ONE;
        end
    end

endmodule

// File: tb/tb_rename_dispatch.sv
// Scoreboard bench for rename_dispatch (default build): a queue-based reference model predicts
// every cycle's outputs; scenario tasks add targeted inline checks.
module tb_rename_dispatch;

    localparam int AR = 16;
    localparam int PR = 32;

    logic       clk = 1'b0;
    logic       reset;
    logic       dec_valid;
    logic [3:0] dec_func;
    logic [3:0] dec_src1, dec_src2, dec_dst;
    logic       dec_ready;
    logic       iq_full;
    logic       iq_load;
    logic [3:0] iq_insn;
    logic [4:0] iq_inp1, iq_inp2, iq_dst, iq_old_dst;
    logic       free_valid;
    logic [4:0] free_preg;
    logic [5:0] free_count;

    rename_dispatch dut (
        .clk(clk), .reset(reset),
        .dec_valid(dec_valid), .dec_func(dec_func), .dec_src1(dec_src1), .dec_src2(dec_src2),
        .dec_dst(dec_dst), .dec_ready(dec_ready), .iq_full(iq_full), .iq_load(iq_load),
        .iq_insn(iq_insn), .iq_inp1(iq_inp1), .iq_inp2(iq_inp2), .iq_dst(iq_dst),
        .iq_old_dst(iq_old_dst), .free_valid(free_valid), .free_preg(free_preg),
        .free_count(free_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ready;
        logic       load;
        logic [3:0] insn;
        logic [4:0] inp1;
        logic [4:0] inp2;
        logic [4:0] dst;
        logic [4:0] old;
        logic [5:0] cnt;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [4:0] m_map[AR];
    logic [4:0] m_fl[$];

    task automatic model_reset();
        m_fl.delete();
        for (int i = 0; i < AR; i++) m_map[i] = 5'(i);
        for (int i = AR; i < PR; i++) m_fl.push_back(5'(i));
    endtask

    // Drive one cycle of stimulus at posedge+1, queue the prediction, return at the negedge.
    task automatic drive(input logic v, input logic [3:0] f, input logic [3:0] s1, input logic [3:0] s2,
                         input logic [3:0] d, input logic full, input logic fv, input logic [4:0] fp);
        exp_t e;
        dec_valid = v; dec_func = f; dec_src1 = s1; dec_src2 = s2; dec_dst = d;
        iq_full = full; free_valid = fv; free_preg = fp;
        e.ready = !full && (m_fl.size() != 0 || d == 4'd0);
        e.load  = v && e.ready;
        e.insn  = e.load ? f : 4'd0;
        e.inp1  = e.load ? m_map[s1] : 5'd0;
        e.inp2  = e.load ? m_map[s2] : 5'd0;
        e.dst   = (e.load && d != 4'd0) ? m_fl[0] : 5'd0;
        e.old   = (e.load && d != 4'd0) ? m_map[d] : 5'd0;
        e.cnt   = 6'(m_fl.size());
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic commit();
        bit rdy;
        bit push_ok;
        @(posedge clk);
        rdy     = !iq_full && (m_fl.size() != 0 || dec_dst == 4'd0);
        push_ok = free_valid && free_preg != 5'd0 && m_fl.size() != PR - 1;
        if (dec_valid && rdy && dec_dst != 4'd0) m_map[dec_dst] = m_fl.pop_front();
        if (push_ok) m_fl.push_back(free_preg);
        #1;
    endtask

    task automatic idle_inputs();
        dec_valid = 0; dec_func = 0; dec_src1 = 0; dec_src2 = 0; dec_dst = 0;
        iq_full = 0; free_valid = 0; free_preg = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        @(posedge clk);
        #1 reset = 0;
        model_reset();
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            if (iq_load) $display("txn insn=%0d inp1=%0d inp2=%0d dst=%0d old=%0d cnt=%0d",
                                  iq_insn, iq_inp1, iq_inp2, iq_dst, iq_old_dst, free_count);
            checks++; if (dec_ready !== e.ready) begin errors++; $display("FAIL sb_ready: got %0d expected %0d", dec_ready, e.ready); end
            checks++; if (iq_load !== e.load) begin errors++; $display("FAIL sb_load: got %0d expected %0d", iq_load, e.load); end
            checks++; if (iq_insn !== e.insn) begin errors++; $display("FAIL sb_insn: got %0d expected %0d", iq_insn, e.insn); end
            checks++; if (iq_inp1 !== e.inp1) begin errors++; $display("FAIL sb_inp1: got %0d expected %0d", iq_inp1, e.inp1); end
            checks++; if (iq_inp2 !== e.inp2) begin errors++; $display("FAIL sb_inp2: got %0d expected %0d", iq_inp2, e.inp2); end
            checks++; if (iq_dst !== e.dst) begin errors++; $display("FAIL sb_dst: got %0d expected %0d", iq_dst, e.dst); end
            checks++; if (iq_old_dst !== e.old) begin errors++; $display("FAIL sb_old_dst: got %0d expected %0d", iq_old_dst, e.old); end
            checks++; if (free_count !== e.cnt) begin errors++; $display("FAIL sb_count: got %0d expected %0d", free_count, e.cnt); end
        end
    end

    task automatic test_reset();
        idle_inputs();
        dec_valid = 1; dec_dst = 4'd3;
        reset = 1;
        @(negedge clk);
        checks++; if (iq_load !== 1'b0) begin errors++; $display("FAIL rst_load: got %0d expected 0", iq_load); end
        checks++; if (dec_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %0d expected 0", dec_ready); end
        checks++; if (free_count !== 6'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", free_count); end
        @(posedge clk);
        #1 reset = 0;
        dec_valid = 0;
        model_reset();
        #1;
        checks++; if (free_count !== 6'd16) begin errors++; $display("FAIL rst_count_after: got %0d expected 16", free_count); end
        checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after: got %0d expected 1", dec_ready); end
    endtask

    task automatic test_rename_basic();
        drive(1, 4'd1, 4'd1, 4'd2, 4'd3, 0, 0, 5'd0);
        checks++; if (iq_inp1 !== 5'd1 || iq_inp2 !== 5'd2) begin errors++; $display("FAIL add_srcs: got %0d,%0d expected 1,2", iq_inp1, iq_inp2); end
        checks++; if (iq_dst !== 5'd16 || iq_old_dst !== 5'd3) begin errors++; $display("FAIL add_dst: got %0d,%0d expected 16,3", iq_dst, iq_old_dst); end
        commit();
        checks++; if (free_count !== 6'd15) begin errors++; $display("FAIL add_count: got %0d expected 15", free_count); end
        drive(1, 4'd2, 4'd3, 4'd3, 4'd3, 0, 0, 5'd0);
        checks++; if (iq_inp1 !== 5'd16 || iq_inp2 !== 5'd16) begin errors++; $display("FAIL sub_srcs: got %0d,%0d expected 16,16", iq_inp1, iq_inp2); end
        checks++; if (iq_dst !== 5'd17 || iq_old_dst !== 5'd16) begin errors++; $display("FAIL sub_dst: got %0d,%0d expected 17,16", iq_dst, iq_old_dst); end
        commit();
    endtask

    task automatic test_iq_full();
        logic [5:0] cnt0;
        cnt0 = free_count;
        for (int i = 0; i < 3; i++) begin
            drive(1, 4'd3, 4'd4, 4'd5, 4'd6, 1, 0, 5'd0);
            checks++; if (dec_ready !== 1'b0 || iq_load !== 1'b0) begin errors++; $display("FAIL full_block: got ready=%0d load=%0d expected 0,0", dec_ready, iq_load); end
            commit();
        end
        checks++; if (free_count !== cnt0) begin errors++; $display("FAIL full_count: got %0d expected %0d", free_count, cnt0); end
        drive(1, 4'd3, 4'd4, 4'd5, 4'd6, 0, 0, 5'd0);
        checks++; if (iq_load !== 1'b1) begin errors++; $display("FAIL full_release: got %0d expected 1", iq_load); end
        commit();
    endtask

    task automatic test_free_list_exhaust();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(1, 4'd1, 4'(i), 4'(i + 1), 4'((i % 15) + 1), 0, 0, 5'd0);
            commit();
        end
        checks++; if (free_count !== 6'd0) begin errors++; $display("FAIL exh_count: got %0d expected 0", free_count); end
        drive(1, 4'd1, 4'd1, 4'd2, 4'd5, 0, 0, 5'd0);
        checks++; if (dec_ready !== 1'b0) begin errors++; $display("FAIL exh_ready: got %0d expected 0", dec_ready); end
        commit();
        drive(1, 4'd4, 4'd1, 4'd2, 4'd0, 0, 0, 5'd0);
        checks++; if (iq_load !== 1'b1 || iq_dst !== 5'd0) begin errors++; $display("FAIL exh_dst0: got load=%0d dst=%0d expected 1,0", iq_load, iq_dst); end
        commit();
        drive(1, 4'd1, 4'd2, 4'd3, 4'd7, 0, 1, 5'd5);
        checks++; if (dec_ready !== 1'b0) begin errors++; $display("FAIL exh_nobypass: got %0d expected 0", dec_ready); end
        commit();
        drive(1, 4'd1, 4'd2, 4'd3, 4'd7, 0, 0, 5'd0);
        checks++; if (dec_ready !== 1'b1 || iq_dst !== 5'd5) begin errors++; $display("FAIL exh_refill: got ready=%0d dst=%0d expected 1,5", dec_ready, iq_dst); end
        commit();
    endtask

    task automatic test_push_pop_same_cycle();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1, 4'd2, 4'd1, 4'd2, 4'd9, 0, 0, 5'd0);
            commit();
        end
        drive(1, 4'd2, 4'd1, 4'd2, 4'd4, 0, 1, 5'd20);
        commit();
        checks++; if (free_count !== 6'd8) begin errors++; $display("FAIL pp_count: got %0d expected 8", free_count); end
        for (int i = 0; i < 8; i++) begin
            drive(1, 4'd2, 4'd4, 4'd1, 4'd10, 0, 0, 5'd0);
            if (i == 7) begin
                checks++; if (iq_dst !== 5'd20) begin errors++; $display("FAIL pp_tail: got %0d expected 20", iq_dst); end
            end
            commit();
        end
    endtask

    task automatic test_free_boundaries();
        do_reset();
        drive(0, 4'd0, 4'd0, 4'd0, 4'd0, 0, 1, 5'd0);
        commit();
        checks++; if (free_count !== 6'd16) begin errors++; $display("FAIL free_zero: got %0d expected 16", free_count); end
        for (int i = 0; i < 16; i++) begin
            drive(0, 4'd0, 4'd0, 4'd0, 4'd0, 0, 1, 5'd9);
            commit();
        end
        checks++; if (free_count !== 6'd31) begin errors++; $display("FAIL free_overflow: got %0d expected 31", free_count); end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1, 4'd1, 4'd2, 4'd3, 4'd3, 0, 0, 5'd0);
            commit();
        end
        dec_valid = 1; dec_dst = 4'd6;
        reset = 1;
        #2;
        checks++; if (iq_load !== 1'b0 || free_count !== 6'd0) begin errors++; $display("FAIL mid_rst_outs: got load=%0d cnt=%0d expected 0,0", iq_load, free_count); end
        do_reset();
        drive(1, 4'd1, 4'd3, 4'd1, 4'd3, 0, 0, 5'd0);
        checks++; if (iq_inp1 !== 5'd3 || iq_dst !== 5'd16) begin errors++; $display("FAIL mid_rst_map: got inp1=%0d dst=%0d expected 3,16", iq_inp1, iq_dst); end
        checks++; if (free_count !== 6'd16) begin errors++; $display("FAIL mid_rst_count: got %0d expected 16", free_count); end
        commit();
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 200; i++) begin
            drive(($urandom % 4) != 0, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                  ($urandom % 5) == 0, ($urandom % 3) == 0, 5'($urandom));
            commit();
        end
    endtask

    initial begin
        test_reset();
        test_rename_basic();
        test_iq_full();
        test_free_list_exhaust();
        test_push_pop_same_cycle();
        test_free_boundaries();
        test_reset_midstream();
        test_back_to_back();
        idle_inputs();
        @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
